axis_downsizer: RTL and testbench

- Width-converting stage directly upstream of the AXIS skid buffer in the fetch/decode path.
- Accepts one wide AXIS beat of RATIO lanes and emits the lanes one per beat, lane 0 first, on a narrower AXIS manager port.
- Typical use: 64-bit fetch words in, 32-bit instruction words out to the skid buffer.
- Registered output; full throughput of one narrow beat per cycle with no bubbles between wide beats.

---
 rtl/axis_pkg.sv | 16 +
 rtl/axis_if.sv | 11 +
 rtl/axis_downsizer.sv | 91 +++++++++
 tb/tb_axis_downsizer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared AXIS helpers: width legality check and lane-index width sizing.
package axis_pkg;

  // True when a wide bus splits evenly into two or more narrow lanes.
  function automatic bit widths_ok(input int unsigned in_w, input int unsigned out_w);
    if (out_w == 0) return 1'b0;
    if ((in_w % out_w) != 0) return 1'b0;
    return (in_w / out_w) >= 2;
  endfunction

  // Index width for n lanes, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle: valid/ready handshake plus data.
interface axis_if #(
  parameter int unsigned TDATA_WIDTH = 32
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;

  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_downsizer.sv
// AXIS width downsizer: one wide beat in, its lanes out one per beat, lane 0 first.
// Optional flush on `invalidate` is enabled by defining AXIS_DOWNSIZER_FLUSH_EN.
module axis_downsizer
  import axis_pkg::*;
(
  input  logic clk,
  input  logic rst,
  axis_if.s    axis_sif,
  axis_if.m    axis_mif,
  input  logic invalidate
);

  localparam int unsigned IN_WIDTH  = $bits(axis_sif.tdata);
  localparam int unsigned OUT_WIDTH = $bits(axis_mif.tdata);
  localparam int unsigned RATIO     = (OUT_WIDTH > 0) ? (IN_WIDTH / OUT_WIDTH) : 1;
  localparam int unsigned IDX_W     = clog2_min1(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  // Reject bus pairings that do not split into whole lanes.
  if (!widths_ok(IN_WIDTH, OUT_WIDTH)) begin : g_width_check
    $fatal(1, "axis_downsizer: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
  end

  logic [IN_WIDTH-1:0] buf_q, buf_d;
  logic                valid_q, valid_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic [RATIO-1:0][OUT_WIDTH-1:0] lanes;
  logic last_c;
  logic flush_c;
  logic sif_ready_c;
  logic s_hs_c;
  logic m_hs_c;

`ifdef AXIS_DOWNSIZER_FLUSH_EN
  assign flush_c = invalidate;
`else
  logic unused_invalidate;
  assign unused_invalidate = invalidate;
  assign flush_c = 1'b0;
`endif

  assign lanes  = buf_q;
  assign last_c = valid_q && (idx_q == LAST_IDX);

  // Accept a new wide beat when empty, or as the final lane leaves (zero-bubble refill).
  assign sif_ready_c = !rst && !flush_c && (!valid_q || (last_c && axis_mif.tready));
  assign s_hs_c      = axis_sif.tvalid && sif_ready_c;
  assign m_hs_c      = valid_q && axis_mif.tready;

  assign axis_sif.tready = sif_ready_c;
  assign axis_mif.tvalid = valid_q;
  assign axis_mif.tdata  = lanes[idx_q];

  // Next-state: load on input handshake, advance lane on output handshake, flush wins.
  always_comb begin
    buf_d   = buf_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    if (s_hs_c) begin
      buf_d   = axis_sif.tdata;
      valid_d = 1'b1;
      idx_d   = '0;
    end else if (m_hs_c) begin
      if (last_c) begin
        valid_d = 1'b0;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
    if (flush_c) begin
      valid_d = 1'b0;
      idx_d   = '0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      buf_q   <= buf_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_axis_downsizer.sv
// Self-checking bench for axis_downsizer (64-bit in, 32-bit out).
module tb_axis_downsizer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic invalidate = 1'b0;

  int checks = 0;
  int errors = 0;

  axis_if #(.TDATA_WIDTH(64)) sif ();
  axis_if #(.TDATA_WIDTH(32)) mif ();

  axis_downsizer dut (
    .clk        (clk),
    .rst        (rst),
    .axis_sif   (sif),
    .axis_mif   (mif),
    .invalidate (invalidate)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    sif.tvalid = 1'b0;
    sif.tdata  = '0;
    mif.tready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (mif.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", mif.tvalid); end
    checks++; if (mif.tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got %h exp 0", mif.tdata); end
    checks++; if (sif.tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b exp 0", sif.tready); end
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (sif.tready !== 1'b1) begin errors++; $display("FAIL idle_tready got %b exp 1", sif.tready); end
  endtask

  task automatic test_single();
    @(negedge clk);
    sif.tdata = 64'h11111111_22222222; sif.tvalid = 1'b1; mif.tready = 1'b1;
    #1;
    checks++; if (sif.tready !== 1'b1) begin errors++; $display("FAIL single_accept got %b exp 1", sif.tready); end
    @(negedge clk);
    sif.tvalid = 1'b0;
    checks++; if (mif.tvalid !== 1'b1 || mif.tdata !== 32'h22222222) begin errors++; $display("FAIL single_lane0 got %b/%h exp 1/22222222", mif.tvalid, mif.tdata); end
    @(negedge clk);
    checks++; if (mif.tvalid !== 1'b1 || mif.tdata !== 32'h11111111) begin errors++; $display("FAIL single_lane1 got %b/%h exp 1/11111111", mif.tvalid, mif.tdata); end
    @(negedge clk);
    checks++; if (mif.tvalid !== 1'b0) begin errors++; $display("FAIL single_empty got %b exp 0", mif.tvalid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'hAAAA0000; exp_d[1] = 32'hAAAA0001;
    exp_d[2] = 32'hBBBB0000; exp_d[3] = 32'hBBBB0001;
    @(negedge clk);
    sif.tdata = 64'hAAAA0001_AAAA0000; sif.tvalid = 1'b1; mif.tready = 1'b1;
    @(negedge clk);
    sif.tdata = 64'hBBBB0001_BBBB0000;
    #1;
    checks++; if (sif.tready !== 1'b0) begin errors++; $display("FAIL b2b_busy_tready got %b exp 0", sif.tready); end
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        checks++; if (sif.tready !== 1'b1) begin errors++; $display("FAIL b2b_refill_tready got %b exp 1", sif.tready); end
      end
      checks++; if (mif.tvalid !== 1'b1 || mif.tdata !== exp_d[i]) begin errors++; $display("FAIL b2b_lane%0d got %b/%h exp 1/%h", i, mif.tvalid, mif.tdata, exp_d[i]); end
      @(negedge clk);
      if (i == 1) sif.tvalid = 1'b0;
      #1;
    end
    checks++; if (mif.tvalid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", mif.tvalid); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    sif.tdata = 64'hDEADBEEF_CAFEF00D; sif.tvalid = 1'b1; mif.tready = 1'b0;
    @(negedge clk);
    sif.tvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (mif.tvalid !== 1'b1 || mif.tdata !== 32'hCAFEF00D) begin errors++; $display("FAIL stall_hold%0d got %b/%h exp 1/cafef00d", i, mif.tvalid, mif.tdata); end
      checks++; if (sif.tready !== 1'b0) begin errors++; $display("FAIL stall_tready%0d got %b exp 0", i, sif.tready); end
      if (i < 2) @(negedge clk);
    end
    mif.tready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (mif.tvalid !== 1'b1 || mif.tdata !== 32'hDEADBEEF) begin errors++; $display("FAIL stall_lane1 got %b/%h exp 1/deadbeef", mif.tvalid, mif.tdata); end
    @(negedge clk);
    checks++; if (mif.tvalid !== 1'b0) begin errors++; $display("FAIL stall_empty got %b exp 0", mif.tvalid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    sif.tdata = 64'h99999999_88888888; sif.tvalid = 1'b1; mif.tready = 1'b1;
    @(negedge clk);
    sif.tvalid = 1'b0; mif.tready = 1'b0;
    checks++; if (mif.tdata !== 32'h88888888) begin errors++; $display("FAIL rstmid_lane0 got %h exp 88888888", mif.tdata); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mif.tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_async got %b exp 0", mif.tvalid); end
    checks++; if (sif.tready !== 1'b0) begin errors++; $display("FAIL rstmid_tready got %b exp 0", sif.tready); end
    @(negedge clk);
    rst = 1'b0; mif.tready = 1'b1;
    @(negedge clk);
    checks++; if (mif.tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_no_lane1 got %b exp 0", mif.tvalid); end
    sif.tdata = 64'h00000002_00000001; sif.tvalid = 1'b1;
    @(negedge clk);
    sif.tvalid = 1'b0;
    checks++; if (mif.tvalid !== 1'b1 || mif.tdata !== 32'h1) begin errors++; $display("FAIL rstmid_next0 got %b/%h exp 1/1", mif.tvalid, mif.tdata); end
    @(negedge clk);
    checks++; if (mif.tvalid !== 1'b1 || mif.tdata !== 32'h2) begin errors++; $display("FAIL rstmid_next1 got %b/%h exp 1/2", mif.tvalid, mif.tdata); end
    @(negedge clk);
  endtask

  task automatic test_invalidate();
    @(negedge clk);
    sif.tdata = 64'h0000000B_0000000A; sif.tvalid = 1'b1; mif.tready = 1'b0;
    @(negedge clk);
    sif.tvalid = 1'b0;
    checks++; if (mif.tvalid !== 1'b1 || mif.tdata !== 32'hA) begin errors++; $display("FAIL inv_lane0 got %b/%h exp 1/a", mif.tvalid, mif.tdata); end
    invalidate = 1'b1;
    #1;
`ifdef AXIS_DOWNSIZER_FLUSH_EN
    checks++; if (sif.tready !== 1'b0) begin errors++; $display("FAIL inv_tready got %b exp 0", sif.tready); end
    @(negedge clk);
    invalidate = 1'b0;
    checks++; if (mif.tvalid !== 1'b0) begin errors++; $display("FAIL inv_flushed got %b exp 0", mif.tvalid); end
    sif.tdata = 64'h00000002_00000001; sif.tvalid = 1'b1; mif.tready = 1'b1;
    @(negedge clk);
    sif.tvalid = 1'b0;
    checks++; if (mif.tvalid !== 1'b1 || mif.tdata !== 32'h1) begin errors++; $display("FAIL inv_next0 got %b/%h exp 1/1", mif.tvalid, mif.tdata); end
    @(negedge clk);
    checks++; if (mif.tvalid !== 1'b1 || mif.tdata !== 32'h2) begin errors++; $display("FAIL inv_next1 got %b/%h exp 1/2", mif.tvalid, mif.tdata); end
`else
    @(negedge clk);
    invalidate = 1'b0;
    checks++; if (mif.tvalid !== 1'b1 || mif.tdata !== 32'hA) begin errors++; $display("FAIL inv_ignored got %b/%h exp 1/a", mif.tvalid, mif.tdata); end
    mif.tready = 1'b1;
    @(negedge clk);
    checks++; if (mif.tvalid !== 1'b1 || mif.tdata !== 32'hB) begin errors++; $display("FAIL inv_lane1 got %b/%h exp 1/b", mif.tvalid, mif.tdata); end
`endif
    @(negedge clk);
    checks++; if (mif.tvalid !== 1'b0) begin errors++; $display("FAIL inv_empty got %b exp 0", mif.tvalid); end
  endtask

  // Random traffic against a queue of pending narrow words.
  task automatic test_random();
    logic [31:0] q [$];
    logic exp_rdy;
    q.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      checks++; if (mif.tvalid !== (q.size() != 0)) begin errors++; $display("FAIL rand_tvalid cyc %0d got %b exp %b", cyc, mif.tvalid, q.size() != 0); end
      if (q.size() != 0) begin
        checks++; if (mif.tdata !== q[0]) begin errors++; $display("FAIL rand_tdata cyc %0d got %h exp %h", cyc, mif.tdata, q[0]); end
      end
      sif.tvalid = ($urandom_range(0, 3) != 0);
      sif.tdata  = {$urandom, $urandom};
      mif.tready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = (q.size() == 0) || (q.size() == 1 && mif.tready);
      checks++; if (sif.tready !== exp_rdy) begin errors++; $display("FAIL rand_tready cyc %0d got %b exp %b", cyc, sif.tready, exp_rdy); end
      if (q.size() != 0 && mif.tready) void'(q.pop_front());
      if (sif.tvalid && exp_rdy) begin
        q.push_back(sif.tdata[31:0]);
        q.push_back(sif.tdata[63:32]);
      end
    end
    sif.tvalid = 1'b0;
    mif.tready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_invalidate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
